// File: rtl/multiplier_pkg.sv
// Shared datapath width, Montgomery-encode FSM states and bitlength clamp.
package multiplier_pkg;

   localparam int DATA_LENGTH = 64;
   localparam int CNT_W       = $clog2(DATA_LENGTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } montgomery_encode_state_t;

   function automatic logic [CNT_W-1:0] clamp_bl(
      input logic [DATA_LENGTH-1:0] q_bl
   );
      if (q_bl > DATA_LENGTH'(DATA_LENGTH))
         return CNT_W'(DATA_LENGTH);
      else
         return q_bl[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/mod_dbl_sub.sv
// Conditional subtract of q from r or 2r; the doubling carry acts as the
// (W+1)-th bit, so the difference always fits in W bits when r < q.
module mod_dbl_sub
   import multiplier_pkg::*;
(
   input  logic [DATA_LENGTH-1:0] i_r,
   input  logic [DATA_LENGTH-1:0] i_q,
   input  logic                   i_dbl,
   output logic [DATA_LENGTH-1:0] o_res
);

   logic                   w_carry;
   logic [DATA_LENGTH-1:0] w_t;
   logic                   w_ge;

   assign w_carry = i_dbl & i_r[DATA_LENGTH-1];
   assign w_t     = i_dbl ? {i_r[DATA_LENGTH-2:0], 1'b0} : i_r;
   assign w_ge    = w_carry | (w_t >= i_q);
   assign o_res   = w_ge ? (w_t - i_q) : w_t;

endmodule

// File: rtl/montgomery_encode.sv
// Iterative x*2^k mod q: one reduction of x, then k modular doublings.
module montgomery_encode
   import multiplier_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [DATA_LENGTH-1:0] x_i,
   input  logic [DATA_LENGTH-1:0] q_i,
   input  logic [DATA_LENGTH-1:0] q_bl_i,
   output logic [DATA_LENGTH-1:0] result_o,
   output logic                   valid_o,
   output logic                   busy_o
);

   montgomery_encode_state_t r_state;
   montgomery_encode_state_t w_next;

   logic [DATA_LENGTH-1:0] r_r;
   logic [DATA_LENGTH-1:0] r_q;
   logic [DATA_LENGTH-1:0] r_result;
   logic [CNT_W-1:0]       r_k;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_valid;
   logic [DATA_LENGTH-1:0] w_red;
   logic                   w_dbl;

   // LOAD reuses the same core with doubling bypassed
   assign w_dbl = (r_state == SHIFT);

   mod_dbl_sub u_dbl (
      .i_r   (r_r),
      .i_q   (r_q),
      .i_dbl (w_dbl),
      .o_res (w_red)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start_i) w_next = LOAD;
         LOAD:    w_next = (r_k == '0) ? DONE : SHIFT;
         SHIFT:   if (r_cnt == CNT_W'(1)) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_r      <= '0;
         r_q      <= '0;
         r_k      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= (w_next == DONE);
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_r <= x_i;
                  r_q <= q_i;
                  r_k <= clamp_bl(q_bl_i);
               end
            end
            LOAD: begin
               r_r   <= w_red;
               r_cnt <= r_k;
               if (r_k == '0) r_result <= w_red;
            end
            SHIFT: begin
               r_r   <= w_red;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_result <= w_red;
            end
            default: ;
         endcase
      end
   end

   assign result_o = r_result;
   assign valid_o  = r_valid;
   assign busy_o   = (r_state != IDLE);

endmodule

// File: tb/tb_montgomery_encode.sv
// Directed checks of montgomery_encode: values, latency, handshake, reset.
module tb_montgomery_encode;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] x;
   logic [63:0] q;
   logic [63:0] bl;
   logic [63:0] result;
   logic        valid;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [63:0] QBIG = 64'hFFFF_FFFF_FFFF_FFC5;

   montgomery_encode dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .x_i      (x),
      .q_i      (q),
      .q_bl_i   (bl),
      .result_o (result),
      .valid_o  (valid),
      .busy_o   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [63:0] xv,
                        input logic [63:0] qv, input logic [63:0] blv,
                        input logic [63:0] exp, input int lat);
      int n;
      @(negedge clk);
      x = xv; q = qv; bl = blv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk({tag, "_busy_hi"}, 64'(busy), 64'd1);
      n = 0;
      while (!valid && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(lat));
      chk({tag, "_res"}, result, exp);
      @(posedge clk);
      #1;
      chk({tag, "_valid_pulse"}, 64'(valid), 64'd0);
      chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int first_t;
      int second_t;
      int nvalid;
      int n;
      rst = 1'b1; start = 1'b0; x = '0; q = '0; bl = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result, 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk) rst = 1'b0;

      do_op("q17_x3", 64'd3, 64'd17, 64'd5, 64'd11, 6);
      do_op("q17_x19", 64'd19, 64'd17, 64'd5, 64'd13, 6);
      do_op("q17_x0", 64'd0, 64'd17, 64'd5, 64'd0, 6);
      do_op("k0_x20", 64'd20, 64'd17, 64'd0, 64'd3, 1);
      do_op("q3_x5", 64'd5, 64'd3, 64'd2, 64'd2, 3);
      do_op("q255_x200", 64'd200, 64'd255, 64'd8, 64'd200, 9);
      do_op("big_x1", 64'd1, QBIG, 64'd64, 64'd59, 65);
      do_op("big_xqm1", QBIG - 64'd1, QBIG, 64'd64,
            64'hFFFF_FFFF_FFFF_FF8A, 65);
      do_op("clamp_bl", 64'd1, QBIG, 64'd100, 64'd59, 65);

      // start held high: ops accepted at edges 0, 8, 16
      @(negedge clk);
      x = 64'd3; q = 64'd17; bl = 64'd5; start = 1'b1;
      first_t = -1; second_t = -1; nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            nvalid++;
            if (first_t < 0) first_t = i;
            else if (second_t < 0) second_t = i;
         end
      end
      start = 1'b0;
      chk("b2b_count", 64'(nvalid), 64'd2);
      chk("b2b_first", 64'(first_t), 64'd6);
      chk("b2b_second", 64'(second_t), 64'd14);
      chk("b2b_res", result, 64'd11);
      n = 0;
      while (busy && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("b2b_drain", 64'(busy), 64'd0);

      // reset in the middle of SHIFT
      @(negedge clk);
      x = 64'd19; q = 64'd17; bl = 64'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_result", result, 64'd0);
      chk("mid_rst_valid", 64'(valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk) rst = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 if (valid) nvalid++;
      end
      chk("mid_rst_no_valid", 64'(nvalid), 64'd0);
      do_op("after_rst", 64'd19, 64'd17, 64'd5, 64'd13, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/montgomery_encode.md
# montgomery_encode

Converts an operand into Montgomery form: computes result = x·R mod q with R = 2^k, k = q_bl_i, by an initial conditional subtraction followed by k modular doublings. It is the entry-side counterpart of the pipelined Montgomery reduction, which takes values out of Montgomery form. Operands are encoded here before they enter the multiplier/reduction datapath. The block is iterative, not pipelined: one operation is in flight at a time, with a start/valid handshake and a busy flag.

## Interface
- DATA_LENGTH, 64 (taken from multiplier_pkg): operand width W.
- clk_i  input  1  rising-edge clock; single clock domain.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- x_i  input  W  operand; must satisfy x_i < 2·q_i.
- q_i  input  W  modulus; odd, q_i ≥ 3, q_i < 2^k.
- q_bl_i  input  W  modulus bitlength k; values above W are clamped to W.
- result_o  output  W  x·2^k mod q; holds its value until the next completion.
- valid_o  output  1  one-cycle pulse; result_o is valid in this cycle.
- busy_o  output  1  high whenever state ≠ IDLE.

## Operation
- Reset (asynchronous, any state): state = IDLE, result_o = 0, valid_o = 0, busy_o = 0, internal registers = 0. An in-flight operation is discarded and produces no valid_o pulse.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - if start_i = 1: capture x_i, q_i and k = min(q_bl_i, W), then go to LOAD.
  - otherwise stay in IDLE.
- LOAD:
  - r ← (x ≥ q) ? x − q : x, so r < q.
  - cnt ← k.
  - if k = 0: result_o ← r, go to DONE.
  - otherwise go to SHIFT.
- SHIFT, one doubling per cycle:
  - t = {r, 1'b0}, a (W+1)-bit value; r ← (t ≥ q) ? t − q : t.
  - cnt ← cnt − 1.
  - when cnt = 1: the doubled value is written to result_o and the FSM goes to DONE.
- DONE: valid_o = 1 for exactly this cycle, then IDLE.
- start_i is ignored in LOAD, SHIFT and DONE; it is not queued.
- Width rules:
  - the comparison and subtraction are W+1 bits wide, so there is no overflow at k = W or with q near 2^W.
  - the result is truncated to W bits, which is lossless because r < q.
- Preconditions are not checked in hardware; a violation gives an unspecified result_o but a correct handshake.

## Timing
- Take edge 0 as the edge that samples start_i in IDLE. busy_o is 1 from edge 0 onward.
- k ≥ 1: edge 1 performs LOAD, edges 2..k+1 perform the doublings, valid_o is high in the cycle after edge k+1 (state DONE), and busy_o drops after edge k+2.
- k = 0: valid_o is high in the cycle after edge 1.
- Latency from the start edge to valid_o is k+1 cycles. The minimum start-to-start interval is k+3 cycles.
- valid_o and result_o are registered outputs with no combinational path from the inputs.
- A start_i held high continuously produces back-to-back operations spaced k+3 cycles apart.

## Structure
- multiplier_pkg: reuse DATA_LENGTH. Add the montgomery_encode_state_t enum (IDLE, LOAD, SHIFT, DONE) and a function clamp_bl(q_bl) returning min(q_bl, DATA_LENGTH).
- One combinational sub-module, mod_dbl_sub (inputs r and q, output (2r ≥ q) ? 2r − q : 2r), is instantiated once. Its compare/subtract core is also used in LOAD with a doubling bypass.
- Counter width: $clog2(DATA_LENGTH+1) bits.

## Test plan
- q=17, k=5, x=3 → result_o=11 (96 mod 17); valid_o exactly 6 cycles after the start edge; busy_o low again one cycle later.
- q=17, k=5, x=19 (x ≥ q path) → result_o=13. x=0 → 0. k=0 with x=20 → 3 with latency 1.
- q=2^64−59, k=64, x=1 → result_o=59. x=q−1 → 2^64−59−59 = q−59 (exercises the W+1-bit carry path).
- Assert start_i on every cycle during SHIFT and DONE → exactly one valid_o per accepted start; the second operation starts k+3 cycles after the first.
- Assert rst_i in the middle of SHIFT → outputs go to 0 immediately; no valid_o pulse; the next start completes correctly.
- Random x < q with odd q and k = bitlength(q): feed result_o to montgomery_pipelined → its output equals x.
